vga_text_write_arbiter: RTL and testbench

// Owns the write side of the 80x40 text display: text RAM, color RAM and cursor registers.

---
 rtl/vga_text_write_arbiter_if.sv | 57 +++++
 rtl/vga_text_write_arbiter.sv | 176 +++++++++++++++++
 tb/tb_vga_text_write_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_text_write_arbiter_if.sv
// Write-side bus of the 80x40 text display.
// The master side is the game core and fill requester. The slave side is the arbiter.
// The slave drives the vga80x40 RAM and cursor write ports.
interface vga_text_write_arbiter_if #(
  parameter int ADDR_W = 12
);
  // single-cell cpu writes
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_char;
  logic [7:0]        cpu_color;
  logic [1:0]        cpu_wmask;
  logic              cpu_ack;

  // block-fill engine control
  logic              fill_start;
  logic [ADDR_W-1:0] fill_base;
  logic [ADDR_W-1:0] fill_len;
  logic [7:0]        fill_char;
  logic [7:0]        fill_color;
  logic              fill_busy;
  logic              fill_done;

  // cursor update request
  logic              cur_req;
  logic [7:0]        cur_x;
  logic [7:0]        cur_y;
  logic              cur_busy;

  // vga80x40 write ports
  logic              wren;
  logic              wrencolor;
  logic [ADDR_W-1:0] wraddress;
  logic [7:0]        wrdata;
  logic [7:0]        wcolor;
  logic              wrencursor;
  logic [1:0]        wcursorAddress;
  logic [7:0]        wcursor;

  modport master (
    output cpu_req, cpu_addr, cpu_char, cpu_color, cpu_wmask,
    output fill_start, fill_base, fill_len, fill_char, fill_color,
    output cur_req, cur_x, cur_y,
    input  cpu_ack, fill_busy, fill_done, cur_busy,
    input  wren, wrencolor, wraddress, wrdata, wcolor,
    input  wrencursor, wcursorAddress, wcursor
  );

  modport slave (
    input  cpu_req, cpu_addr, cpu_char, cpu_color, cpu_wmask,
    input  fill_start, fill_base, fill_len, fill_char, fill_color,
    input  cur_req, cur_x, cur_y,
    output cpu_ack, fill_busy, fill_done, cur_busy,
    output wren, wrencolor, wraddress, wrdata, wcolor,
    output wrencursor, wcursorAddress, wcursor
  );
endinterface

// File: rtl/vga_text_write_arbiter.sv
// Write-side owner of the 80x40 text display: text RAM, color RAM and cursor registers.
// Single-cell cpu writes and a block-fill engine share the RAM write port round-robin.
// Cursor updates are sequenced into the two-entry cursor memory on their own port.
// Every output is registered.
// Optional macro TEXTWR_BOUNDS_CHECK_EN:
//   - A cpu write to an address >= DEPTH is acked with both enables low.
//   - A fill base >= DEPTH starts the fill at cell 0.
module vga_text_write_arbiter #(
  parameter int COLS   = 80,
  parameter int ROWS   = 40,
  parameter int DEPTH  = COLS * ROWS,
  parameter int ADDR_W = 12
) (
  input logic                  clk25MHz,
  input logic                  reset_n,
  vga_text_write_arbiter_if.slave bus
);

  localparam logic [ADDR_W-1:0] L_DEPTH = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] L_LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic { F_IDLE, F_RUN } fillState_t;
  typedef enum logic [1:0] { C_IDLE, C_WX, C_WY } curState_t;

  fillState_t        r_fillState;
  logic [ADDR_W-1:0] r_fillAddr;
  logic [ADDR_W-1:0] r_fillRemain;
  logic [7:0]        r_fillChar;
  logic [7:0]        r_fillColor;
  logic              r_favourCpu;
  curState_t         r_curState;
  logic [7:0]        r_curY;

  logic              w_cpuElig;
  logic              w_fillElig;
  logic              w_grantCpu;
  logic              w_grantFill;
  logic              w_cpuInRange;
  logic [ADDR_W-1:0] w_fillBase;

`ifdef TEXTWR_BOUNDS_CHECK_EN
  assign w_cpuInRange = (bus.cpu_addr < L_DEPTH);
  assign w_fillBase   = (bus.fill_base >= L_DEPTH) ? '0 : bus.fill_base;
`else
  assign w_cpuInRange = 1'b1;
  assign w_fillBase   = bus.fill_base;
`endif

  // The cpu sits out its ack cycle so that a request still held there is not written twice.
  // The requester served most recently yields priority on the next contest.
  assign w_cpuElig   = bus.cpu_req && !bus.cpu_ack;
  assign w_fillElig  = (r_fillState == F_RUN) && (r_fillRemain != '0);
  assign w_grantCpu  = w_cpuElig && (!w_fillElig || r_favourCpu);
  assign w_grantFill = w_fillElig && (!w_cpuElig || !r_favourCpu);

  // RAM write port: issue the granted write and rotate priority
  always_ff @(posedge clk25MHz or negedge reset_n) begin
    if (!reset_n) begin
      bus.cpu_ack   <= 1'b0;
      bus.wren      <= 1'b0;
      bus.wrencolor <= 1'b0;
      bus.wraddress <= '0;
      bus.wrdata    <= '0;
      bus.wcolor    <= '0;
      r_favourCpu   <= 1'b1;
    end else begin
      bus.cpu_ack   <= 1'b0;
      bus.wren      <= 1'b0;
      bus.wrencolor <= 1'b0;
      if (w_grantCpu) begin
        bus.cpu_ack   <= 1'b1;
        bus.wren      <= bus.cpu_wmask[0] && w_cpuInRange;
        bus.wrencolor <= bus.cpu_wmask[1] && w_cpuInRange;
        bus.wraddress <= bus.cpu_addr;
        bus.wrdata    <= bus.cpu_char;
        bus.wcolor    <= bus.cpu_color;
        r_favourCpu   <= 1'b0;
      end else if (w_grantFill) begin
        bus.wren      <= 1'b1;
        bus.wrencolor <= 1'b1;
        bus.wraddress <= r_fillAddr;
        bus.wrdata    <= r_fillChar;
        bus.wcolor    <= r_fillColor;
        r_favourCpu   <= 1'b1;
      end
    end
  end

  // Fill engine: latch the request, then step the address for every granted write.
  // RUN is held for one cycle after the last write so that fill_done and the fall of
  // fill_busy land together in that cycle.
  always_ff @(posedge clk25MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_fillState   <= F_IDLE;
      r_fillAddr    <= '0;
      r_fillRemain  <= '0;
      r_fillChar    <= '0;
      r_fillColor   <= '0;
      bus.fill_busy <= 1'b0;
      bus.fill_done <= 1'b0;
    end else begin
      bus.fill_done <= 1'b0;
      case (r_fillState)
        F_IDLE: begin
          if (bus.fill_start) begin
            r_fillAddr   <= w_fillBase;
            r_fillRemain <= bus.fill_len;
            r_fillChar   <= bus.fill_char;
            r_fillColor  <= bus.fill_color;
            if (bus.fill_len == '0) begin
              bus.fill_done <= 1'b1;
            end else begin
              r_fillState   <= F_RUN;
              bus.fill_busy <= 1'b1;
            end
          end
        end
        F_RUN: begin
          if (w_grantFill) begin
            r_fillAddr   <= (r_fillAddr == L_LAST) ? '0 : r_fillAddr + ADDR_W'(1);
            r_fillRemain <= r_fillRemain - ADDR_W'(1);
          end else if (r_fillRemain == '0) begin
            r_fillState   <= F_IDLE;
            bus.fill_busy <= 1'b0;
            bus.fill_done <= 1'b1;
          end
        end
        default: r_fillState <= F_IDLE;
      endcase
    end
  end

  // Cursor sequencer: write x to entry 0, then y to entry 1
  always_ff @(posedge clk25MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_curState         <= C_IDLE;
      r_curY             <= '0;
      bus.cur_busy       <= 1'b0;
      bus.wrencursor     <= 1'b0;
      bus.wcursorAddress <= '0;
      bus.wcursor        <= '0;
    end else begin
      case (r_curState)
        C_IDLE: begin
          bus.wrencursor <= 1'b0;
          bus.cur_busy   <= 1'b0;
          if (bus.cur_req) begin
            r_curState         <= C_WX;
            r_curY             <= bus.cur_y;
            bus.cur_busy       <= 1'b1;
            bus.wrencursor     <= 1'b1;
            bus.wcursorAddress <= 2'd0;
            bus.wcursor        <= bus.cur_x;
          end
        end
        C_WX: begin
          r_curState         <= C_WY;
          bus.wrencursor     <= 1'b1;
          bus.wcursorAddress <= 2'd1;
          bus.wcursor        <= r_curY;
        end
        C_WY: begin
          r_curState     <= C_IDLE;
          bus.wrencursor <= 1'b0;
          bus.cur_busy   <= 1'b0;
        end
        default: begin
          r_curState     <= C_IDLE;
          bus.wrencursor <= 1'b0;
          bus.cur_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_text_write_arbiter.sv
// Self-checking bench for vga_text_write_arbiter.
// Expected RAM and cursor writes are queued when stimulus is driven.
// A negedge monitor pops the queue whenever the DUT issues a write.
`timescale 1ns/1ps
module tb_vga_text_write_arbiter;

  localparam int DEPTH = 3200;

  logic clk25MHz = 1'b0;
  logic reset_n  = 1'b1;

  // 25 MHz pixel clock
  always #20 clk25MHz = ~clk25MHz;

  vga_text_write_arbiter_if bus ();

  vga_text_write_arbiter dut (
    .clk25MHz (clk25MHz),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  ch;
    logic [7:0]  col;
    logic        en;
    logic        enc;
    logic        ack;
  } wr_t;

  typedef struct {
    logic [1:0] a;
    logic [7:0] d;
  } cur_t;

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  ch;
    logic [7:0]  col;
    logic [1:0]  mask;
    logic        expEn;
    logic        expEnc;
  } cpuVec_t;

  wr_t     expQ[$];
  cur_t    curQ[$];
  cpuVec_t vecs[6];
  wr_t     monW;
  cur_t    monC;
  int      errors    = 0;
  int      checks    = 0;
  int      doneCount = 0;
  int      doneSnap;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every issued write against the scoreboard
  always @(negedge clk25MHz) begin
    if (bus.fill_done === 1'b1) doneCount++;
    if (bus.wren || bus.wrencolor || bus.cpu_ack) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: got addr 0x%0h ack %0b, expected no write",
                 bus.wraddress, bus.cpu_ack);
      end else begin
        monW = expQ.pop_front();
        checkOutput("wr_ack", 32'(bus.cpu_ack), 32'(monW.ack));
        checkOutput("wr_en", 32'({bus.wren, bus.wrencolor}), 32'({monW.en, monW.enc}));
        if (monW.en || monW.enc) begin
          checkOutput("wr_addr", 32'(bus.wraddress), 32'(monW.addr));
          checkOutput("wr_data", 32'({bus.wrdata, bus.wcolor}), 32'({monW.ch, monW.col}));
        end
      end
    end
    if (bus.wrencursor) begin
      if (curQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_cursor: got addr %0d data %0d, expected no write",
                 bus.wcursorAddress, bus.wcursor);
      end else begin
        monC = curQ.pop_front();
        checkOutput("cur_wr", 32'({bus.wcursorAddress, bus.wcursor}), 32'({monC.a, monC.d}));
      end
    end
  end

  // Wait (bounded) for a cpu_ack, sampled on the negedge
  task automatic waitAck();
    int n = 0;
    do begin
      @(negedge clk25MHz);
      n++;
    end while (bus.cpu_ack !== 1'b1 && n < 40);
    checkOutput("ack_seen", 32'(bus.cpu_ack), 32'd1);
  endtask

  // One cpu write from the table; req stays up through the ack edge
  task automatic applyStimulus(input cpuVec_t v);
    expQ.push_back(wr_t'{v.addr, v.ch, v.col, v.expEn, v.expEnc, 1'b1});
    bus.cpu_addr  = v.addr;
    bus.cpu_char  = v.ch;
    bus.cpu_color = v.col;
    bus.cpu_wmask = v.mask;
    bus.cpu_req   = 1'b1;
    waitAck();
    @(posedge clk25MHz);
    #1 bus.cpu_req = 1'b0;
    repeat (2) @(negedge clk25MHz);
  endtask

  // Queue the expected fill writes (address wraps from DEPTH-1 to 0)
  task automatic pushFill(input int base, input int len, input logic [7:0] ch, input logic [7:0] col);
    int a = base;
    for (int i = 0; i < len; i++) begin
      expQ.push_back(wr_t'{12'(a), ch, col, 1'b1, 1'b1, 1'b0});
      a = (a == DEPTH - 1) ? 0 : (a + 1) % 4096;
    end
  endtask

  // Pulse fill_start; called and returning on a negedge
  task automatic pulseFill(input logic [11:0] base, input logic [11:0] len,
                           input logic [7:0] ch, input logic [7:0] col);
    bus.fill_base  = base;
    bus.fill_len   = len;
    bus.fill_char  = ch;
    bus.fill_color = col;
    bus.fill_start = 1'b1;
    @(negedge clk25MHz);
    bus.fill_start = 1'b0;
  endtask

  // Count cycles from the fill_start edge to fill_done and check the pulse
  task automatic waitDone(input string name, input int expN);
    int n = 1;
    if (expN > 1) checkOutput({name, "_busy_start"}, 32'(bus.fill_busy), 32'd1);
    while (bus.fill_done !== 1'b1 && n < 4000) begin
      @(negedge clk25MHz);
      n++;
    end
    checkOutput({name, "_done_cycle"}, 32'(n), 32'(expN));
    checkOutput({name, "_busy_at_done"}, 32'(bus.fill_busy), 32'd0);
    @(negedge clk25MHz);
    checkOutput({name, "_done_pulse"}, 32'(bus.fill_done), 32'd0);
  endtask

  function automatic logic [31:0] allOutputs();
    return 32'({bus.cpu_ack, bus.fill_busy, bus.fill_done, bus.cur_busy, bus.wren, bus.wrencolor,
                bus.wrencursor, bus.wcursorAddress}) | 32'(bus.wraddress) | 32'(bus.wrdata)
         | 32'(bus.wcolor) | 32'(bus.wcursor);
  endfunction

  initial begin
    vecs[0] = '{12'h0A5, 8'h41, 8'h1F, 2'b11, 1'b1, 1'b1};
    vecs[1] = '{12'h000, 8'h30, 8'h02, 2'b01, 1'b1, 1'b0};
    vecs[2] = '{12'hC7F, 8'h5A, 8'h4E, 2'b10, 1'b0, 1'b1};
    vecs[3] = '{12'h123, 8'h00, 8'hFF, 2'b00, 1'b0, 1'b0};
    vecs[4] = '{12'h7FF, 8'hA5, 8'h5A, 2'b11, 1'b1, 1'b1};
`ifdef TEXTWR_BOUNDS_CHECK_EN
    vecs[5] = '{12'hC80, 8'h21, 8'h0C, 2'b11, 1'b0, 1'b0};
`else
    vecs[5] = '{12'hC80, 8'h21, 8'h0C, 2'b11, 1'b1, 1'b1};
`endif

    bus.cpu_req = 1'b0;   bus.cpu_addr = '0;   bus.cpu_char = '0;
    bus.cpu_color = '0;   bus.cpu_wmask = '0;  bus.fill_start = 1'b0;
    bus.fill_base = '0;   bus.fill_len = '0;   bus.fill_char = '0;
    bus.fill_color = '0;  bus.cur_req = 1'b0;  bus.cur_x = '0;  bus.cur_y = '0;

    #5 reset_n = 1'b0;
    #1 checkOutput("reset_outputs", allOutputs(), 32'd0);
    repeat (3) @(negedge clk25MHz);
    reset_n = 1'b1;
    @(negedge clk25MHz);
    checkOutput("idle_after_reset", allOutputs(), 32'd0);

    // table-driven single-cell cpu writes
    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);
    checkOutput("cpu_sb_empty", 32'(expQ.size()), 32'd0);

    // full-screen clear
    pushFill(0, DEPTH, 8'h20, 8'h07);
    doneSnap = doneCount;
    pulseFill(12'd0, 12'd3200, 8'h20, 8'h07);
    waitDone("fill_full", DEPTH + 2);
    checkOutput("fill_full_sb_empty", 32'(expQ.size()), 32'd0);
    checkOutput("fill_full_one_done", 32'(doneCount - doneSnap), 32'd1);

    // wrap from the last cell
    pushFill(3198, 4, 8'h2A, 8'h0E);
    pulseFill(12'd3198, 12'd4, 8'h2A, 8'h0E);
    waitDone("fill_wrap", 6);
    checkOutput("fill_wrap_sb_empty", 32'(expQ.size()), 32'd0);

    // zero-length fill completes at once
    pulseFill(12'd50, 12'd0, 8'h11, 8'h22);
    waitDone("fill_zero", 1);

    // out-of-range fill base
`ifdef TEXTWR_BOUNDS_CHECK_EN
    pushFill(0, 2, 8'h33, 8'h44);
`else
    pushFill(3300, 2, 8'h33, 8'h44);
`endif
    pulseFill(12'd3300, 12'd2, 8'h33, 8'h44);
    waitDone("fill_oob", 4);
    checkOutput("fill_oob_sb_empty", 32'(expQ.size()), 32'd0);

    // cpu held during a 10-cell fill: cpu, fill, cpu, fill ...
    for (int k = 0; k < 10; k++) begin
      expQ.push_back(wr_t'{12'(12'h200 + k), 8'(8'h60 + k), 8'(8'h10 + k), 1'b1, 1'b1, 1'b1});
      expQ.push_back(wr_t'{12'(100 + k), 8'h2E, 8'h03, 1'b1, 1'b1, 1'b0});
    end
    for (int k = 10; k < 12; k++)
      expQ.push_back(wr_t'{12'(12'h200 + k), 8'(8'h60 + k), 8'(8'h10 + k), 1'b1, 1'b1, 1'b1});
    fork
      begin
        for (int k = 0; k < 12; k++) begin
          bus.cpu_addr  = 12'(12'h200 + k);
          bus.cpu_char  = 8'(8'h60 + k);
          bus.cpu_color = 8'(8'h10 + k);
          bus.cpu_wmask = 2'b11;
          bus.cpu_req   = 1'b1;
          waitAck();
        end
        @(posedge clk25MHz);
        #1 bus.cpu_req = 1'b0;
      end
      begin
        pulseFill(12'd100, 12'd10, 8'h2E, 8'h03);
        waitDone("fill_alt", 21);
      end
    join
    repeat (3) @(negedge clk25MHz);
    checkOutput("fill_alt_sb_empty", 32'(expQ.size()), 32'd0);

    // cursor update in the middle of a fill; second cur_req and fill_start are ignored
    pushFill(500, 20, 8'h41, 8'h1E);
    curQ.push_back(cur_t'{2'd0, 8'd40});
    curQ.push_back(cur_t'{2'd1, 8'd20});
    fork
      begin
        pulseFill(12'd500, 12'd20, 8'h41, 8'h1E);
        waitDone("fill_cur", 22);
      end
      begin
        repeat (5) @(negedge clk25MHz);
        bus.cur_x = 8'd40;
        bus.cur_y = 8'd20;
        bus.cur_req = 1'b1;
        @(negedge clk25MHz);
        checkOutput("cur_busy_wx", 32'(bus.cur_busy), 32'd1);
        bus.cur_x = 8'd99;
        bus.cur_y = 8'd98;
        @(negedge clk25MHz);
        bus.cur_req = 1'b0;
        checkOutput("cur_busy_wy", 32'(bus.cur_busy), 32'd1);
        @(negedge clk25MHz);
        checkOutput("cur_busy_end", 32'(bus.cur_busy), 32'd0);
        bus.fill_base = 12'd0;
        bus.fill_len = 12'd5;
        bus.fill_start = 1'b1;
        @(negedge clk25MHz);
        bus.fill_start = 1'b0;
      end
    join
    repeat (3) @(negedge clk25MHz);
    checkOutput("fill_cur_sb_empty", 32'(expQ.size()), 32'd0);
    checkOutput("cur_sb_empty", 32'(curQ.size()), 32'd0);

    // asynchronous reset in the middle of a fill
    pushFill(0, 100, 8'h55, 8'h66);
    pulseFill(12'd0, 12'd100, 8'h55, 8'h66);
    repeat (10) @(negedge clk25MHz);
    doneSnap = doneCount;
    @(posedge clk25MHz);
    #5 reset_n = 1'b0;
    #1 checkOutput("midfill_reset_outputs", allOutputs(), 32'd0);
    expQ.delete();
    repeat (3) @(negedge clk25MHz);
    checkOutput("midfill_busy_low", 32'(bus.fill_busy), 32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk25MHz);
    checkOutput("midfill_no_done", 32'(doneCount - doneSnap), 32'd0);
    pushFill(7, 3, 8'h77, 8'h01);
    pulseFill(12'd7, 12'd3, 8'h77, 8'h01);
    waitDone("fill_after_reset", 5);
    checkOutput("after_reset_sb_empty", 32'(expQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog");
  end

endmodule
